somador_serial_param: RTL and testbench

Parametrised multi-cycle adder/subtractor for the FPGA ALU datapath. It is the successor to the fixed 8-bit ripple-carry adder and generalises it in operand width and digit width. It adds a subtract mode, status flags and a start/done handshake. Each cycle it processes one DIGIT-bit slice with a small ripple adder, trading latency for area so that wide operands fit the ALU.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/somador_digito.sv | 33 +++
 rtl/somador_serial_param.sv | 150 +++++++++++++++
 tb/tb_somador_serial_param.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU datapath blocks.
//   state_t  : control states of the serial adder/subtractor
//   MODE_*   : encoding of the 'sub' mode input
//   clog2    : ceiling log2, used for counter widths
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/somador_digito.sv
// Combinational DIGIT-bit ripple adder built from a chain of full-adder cells.
//   A, B : DIGIT-bit addends
//   Cin  : carry into bit 0
//   S    : DIGIT-bit sum
//   Cout : carry out of the top bit
//   C7   : carry into the top bit (needed for signed overflow detection)
module somador_digito #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] A,
  input  logic [DIGIT-1:0] B,
  input  logic             Cin,
  output logic [DIGIT-1:0] S,
  output logic             Cout,
  output logic             C7
);

  logic [DIGIT:0] carry;

  always_comb begin
    carry    = '0;
    S        = '0;
    carry[0] = Cin;
    for (int i = 0; i < DIGIT; i++) begin
      S[i]       = A[i] ^ B[i] ^ carry[i];
      carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
  end

  assign Cout = carry[DIGIT];
  assign C7   = carry[DIGIT-1];

endmodule

// File: rtl/somador_serial_param.sv
// Multi-cycle adder/subtractor processing one DIGIT-bit slice per clock.
//   clk, rst_n : clock, synchronous active-low reset
//   start, sub : request a new operation (only while not busy); mode 0=A+B, 1=A-B
//   A, B       : WIDTH-bit operands, sampled with start
//   S          : WIDTH-bit result, held between completions
//   cout       : final carry (sub: 1 = no borrow)
//   overflow   : signed overflow of the final slice
//   zero       : S == 0
//   negative   : S[WIDTH-1]
//   busy       : operation in progress
//   done       : one-cycle pulse when a new result is presented
import alu_pkg::*;

module somador_serial_param #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             busy,
  output logic             done
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (clog2(N) < 1) ? 1 : clog2(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("somador_serial_param: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;

  logic [DIGIT-1:0]  dsum;
  logic              dcout;
  logic              dc_msb;
  logic [WIDTH-1:0]  res_shift;

  somador_digito #(.DIGIT(DIGIT)) u_digito (
    .A    (a_q[DIGIT-1:0]),
    .B    (b_q[DIGIT-1:0]),
    .Cin  (carry_q),
    .S    (dsum),
    .Cout (dcout),
    .C7   (dc_msb)
  );

  // New slice enters at the MSB end; after N slices the result is aligned.
  assign res_shift = (res_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;

    case (state_q)
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_shift;
        carry_d = dcout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          s_d     = res_shift;
          cout_d  = dcout;
          ovf_d   = dc_msb ^ dcout;
          zero_d  = (res_shift == '0);
          neg_d   = res_shift[WIDTH-1];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Acceptance from IDLE or DONE; subtraction is A + ~B + 1.
    if (start && state_q != RUN) begin
      state_d = RUN;
      a_d     = A;
      b_d     = (sub == MODE_SUB) ? ~B : B;
      carry_d = sub;
      cnt_d   = '0;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign S        = s_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign negative = neg_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_somador_serial_param.sv
// Directed bench for somador_serial_param: an 8-bit/1-bit-digit instance and a
// 16-bit/4-bit-digit instance sharing clock and reset.
module tb_somador_serial_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        start8, sub8;
  logic [7:0]  a8, b8, s8;
  logic        cout8, ov8, z8, n8, busy8, done8;
  logic        start16, sub16;
  logic [15:0] a16, b16, s16;
  logic        cout16, ov16, z16, n16, busy16, done16;

  logic [3:0] fl8, fl16;
  assign fl8  = {cout8, ov8, z8, n8};
  assign fl16 = {cout16, ov16, z16, n16};

  somador_serial_param #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .A(a8), .B(b8),
    .S(s8), .cout(cout8), .overflow(ov8), .zero(z8), .negative(n8),
    .busy(busy8), .done(done8)
  );

  somador_serial_param #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .A(a16), .B(b16),
    .S(s16), .cout(cout16), .overflow(ov16), .zero(z16), .negative(n16),
    .busy(busy16), .done(done16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one 8-bit operation and wait (bounded) for done.
  // lat = cycles after the start edge at which done is seen.
  task automatic do_op8(input logic sub, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int bcnt);
    start8 = 1'b1; sub8 = sub; a8 = a; b8 = b;
    step();
    start8 = 1'b0;
    lat = 0; bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      step();
      lat++;
    end
  endtask

  task automatic do_op16(input logic sub, input logic [15:0] a, input logic [15:0] b,
                         output int lat);
    start16 = 1'b1; sub16 = sub; a16 = a; b16 = b;
    step();
    start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_cmp++; if (s8 !== 8'h00) begin n_err++; $display("FAIL reset_s8 got %h exp 00", s8); end
    n_cmp++; if (fl8 !== 4'b0000) begin n_err++; $display("FAIL reset_flags8 got %b exp 0000", fl8); end
    n_cmp++; if ({busy8, done8} !== 2'b00) begin n_err++; $display("FAIL reset_bd8 got %b exp 00", {busy8, done8}); end
    n_cmp++; if ({s16, fl16, busy16, done16} !== 22'd0) begin n_err++; $display("FAIL reset_16 got %h exp 0", {s16, fl16, busy16, done16}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    int lat, bcnt;
    do_op8(1'b0, 8'h7F, 8'h01, lat, bcnt);
    n_cmp++; if (lat != 8) begin n_err++; $display("FAIL add_latency got %0d exp 8", lat); end
    n_cmp++; if (bcnt != 8) begin n_err++; $display("FAIL add_busy_cycles got %0d exp 8", bcnt); end
    n_cmp++; if (s8 !== 8'h80) begin n_err++; $display("FAIL add_7f_s got %h exp 80", s8); end
    n_cmp++; if (fl8 !== 4'b0101) begin n_err++; $display("FAIL add_7f_flags got %b exp 0101", fl8); end
    n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL add_busy_in_done got %b exp 0", busy8); end
    step();
    n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("FAIL done_pulse_width got %b exp 0", done8); end
    n_cmp++; if (s8 !== 8'h80) begin n_err++; $display("FAIL s_hold got %h exp 80", s8); end
    do_op8(1'b0, 8'hFF, 8'h01, lat, bcnt);
    n_cmp++; if (s8 !== 8'h00) begin n_err++; $display("FAIL add_ff_s got %h exp 00", s8); end
    n_cmp++; if (fl8 !== 4'b1010) begin n_err++; $display("FAIL add_ff_flags got %b exp 1010", fl8); end
    step();
  endtask

  task automatic test_sub();
    int lat, bcnt;
    do_op8(1'b1, 8'h05, 8'h07, lat, bcnt);
    n_cmp++; if (s8 !== 8'hFE) begin n_err++; $display("FAIL sub_05_07_s got %h exp fe", s8); end
    n_cmp++; if (fl8 !== 4'b0001) begin n_err++; $display("FAIL sub_05_07_flags got %b exp 0001", fl8); end
    step();
    do_op8(1'b1, 8'h80, 8'h01, lat, bcnt);
    n_cmp++; if (s8 !== 8'h7F) begin n_err++; $display("FAIL sub_80_01_s got %h exp 7f", s8); end
    n_cmp++; if (fl8 !== 4'b1100) begin n_err++; $display("FAIL sub_80_01_flags got %b exp 1100", fl8); end
    step();
  endtask

  task automatic test_ignore_start();
    int k;
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h03; b8 = 8'h04;
    step();
    start8 = 1'b0;
    k = 0;
    while (!done8 && k < 40) begin
      if (k == 3) begin start8 = 1'b1; sub8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; end
      else begin start8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; end
      step();
      k++;
    end
    start8 = 1'b0;
    n_cmp++; if (k != 8) begin n_err++; $display("FAIL ignore_latency got %0d exp 8", k); end
    n_cmp++; if (s8 !== 8'h07) begin n_err++; $display("FAIL ignore_s got %h exp 07", s8); end
    step();
    n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL ignore_requeued got busy %b exp 0", busy8); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt, k;
    do_op8(1'b0, 8'h10, 8'h20, lat, bcnt);
    n_cmp++; if (s8 !== 8'h30) begin n_err++; $display("FAIL b2b_first_s got %h exp 30", s8); end
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h01; b8 = 8'h02;
    step();
    start8 = 1'b0;
    n_cmp++; if (busy8 !== 1'b1) begin n_err++; $display("FAIL b2b_accept got busy %b exp 1", busy8); end
    k = 0;
    while (!done8 && k < 40) begin step(); k++; end
    n_cmp++; if (k + 1 != 9) begin n_err++; $display("FAIL b2b_gap got %0d exp 9", k + 1); end
    n_cmp++; if (s8 !== 8'h03) begin n_err++; $display("FAIL b2b_second_s got %h exp 03", s8); end
    step();
  endtask

  task automatic test_reset_mid();
    int k, dcount, lat, bcnt;
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
    step();
    start8 = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if (s8 !== 8'h00) begin n_err++; $display("FAIL rstmid_s got %h exp 00", s8); end
    n_cmp++; if ({fl8, busy8, done8} !== 6'd0) begin n_err++; $display("FAIL rstmid_ctl got %b exp 000000", {fl8, busy8, done8}); end
    dcount = 0;
    for (k = 0; k < 12; k++) begin step(); if (done8 || busy8) dcount++; end
    n_cmp++; if (dcount != 0) begin n_err++; $display("FAIL rstmid_ghost got %0d exp 0", dcount); end
    do_op8(1'b0, 8'h05, 8'h06, lat, bcnt);
    n_cmp++; if (lat != 8) begin n_err++; $display("FAIL rstmid_relat got %0d exp 8", lat); end
    n_cmp++; if (s8 !== 8'h0B) begin n_err++; $display("FAIL rstmid_res got %h exp 0b", s8); end
    step();
  endtask

  task automatic test_wide16();
    int lat;
    do_op16(1'b0, 16'h1234, 16'h4321, lat);
    n_cmp++; if (lat != 4) begin n_err++; $display("FAIL w16_latency got %0d exp 4", lat); end
    n_cmp++; if (s16 !== 16'h5555) begin n_err++; $display("FAIL w16_add_s got %h exp 5555", s16); end
    n_cmp++; if (fl16 !== 4'b0000) begin n_err++; $display("FAIL w16_add_flags got %b exp 0000", fl16); end
    step();
    do_op16(1'b1, 16'h0000, 16'h0001, lat);
    n_cmp++; if (s16 !== 16'hFFFF) begin n_err++; $display("FAIL w16_sub_s got %h exp ffff", s16); end
    n_cmp++; if (fl16 !== 4'b0001) begin n_err++; $display("FAIL w16_sub_flags got %b exp 0001", fl16); end
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_wide16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
